// File: rtl/onchip_mem_copy_master_if.sv
// Avalon-MM bus bundle between the copy master and the on-chip memory slave.
// Word addressing; byteenable width follows the data width.
interface onchip_mem_copy_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;
    logic                avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_read,
        output avm_write,
        output avm_byteenable,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_read,
        input  avm_write,
        input  avm_byteenable,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest,
        output avm_readdatavalid
    );
endinterface

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM block copy master: alternating single-word read/write transfers.
// Define COPY_MASTER_CHECKSUM_EN to add a running sum of written words.
module onchip_mem_copy_master #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_done,
`ifdef COPY_MASTER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    onchip_mem_copy_master_if.master avm
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              abt_q, abt_d;
    logic              rab_q, rab_d;
    logic [DATA_W-1:0] sum_q, sum_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            abt_q   <= 1'b0;
            rab_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            abt_q   <= abt_d;
            rab_q   <= rab_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        abt_d   = abt_q;
        rab_d   = rab_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = length;
                    cnt_d   = '0;
                    abt_d   = 1'b0;
                    rab_d   = 1'b0;
                    sum_d   = '0;
                    state_d = (length == '0) ? FIN : RD;
                end
            end
            RD: begin
                // An accepted read must still be drained, so abort waits in RWAIT
                if (!avm.avm_waitrequest) begin
                    rab_d   = abort;
                    state_d = RWAIT;
                end else if (abort) begin
                    abt_d   = 1'b1;
                    state_d = FIN;
                end
            end
            RWAIT: begin
                if (abort) rab_d = 1'b1;
                if (avm.avm_readdatavalid) begin
                    if (abort || rab_q) begin
                        abt_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        data_d  = avm.avm_readdata;
                        state_d = WR;
                    end
                end
            end
            WR: begin
                if (!avm.avm_waitrequest) begin
                    src_d = src_q + ADDR_W'(1);
                    dst_d = dst_q + ADDR_W'(1);
                    cnt_d = cnt_q + LEN_W'(1);
                    sum_d = sum_q + data_q;
                    if (abort) begin
                        abt_d   = 1'b1;
                        state_d = FIN;
                    end else if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD;
                    end
                end else if (abort) begin
                    abt_d   = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                rab_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic rd_req;
    logic wr_req;

    assign rd_req = (state_q == RD);
    assign wr_req = (state_q == WR);

    assign avm.avm_read       = rd_req;
    assign avm.avm_write      = wr_req;
    assign avm.avm_chipselect = rd_req | wr_req;
    assign avm.avm_byteenable = (rd_req | wr_req) ? '1 : '0;
    assign avm.avm_writedata  = data_q;
    assign avm.avm_address    = wr_req ? dst_q : (rd_req ? src_q : '0);

    assign busy       = rd_req | wr_req | (state_q == RWAIT);
    assign done       = (state_q == FIN);
    assign aborted    = abt_q;
    assign words_done = cnt_q;

`ifdef COPY_MASTER_CHECKSUM_EN
    assign checksum = sum_q;
`else
    logic unused_sum;
    assign unused_sum = ^sum_q;
`endif

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Directed bench for onchip_mem_copy_master against a 512x32 memory model.
// Covers reset, timing, wrap, stalls, abort, busy-start and async reset.
module tb_onchip_mem_copy_master;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] words_done;
`ifdef COPY_MASTER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    onchip_mem_copy_master_if #(.ADDR_W(AW), .DATA_W(DW)) avm ();

    onchip_mem_copy_master #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .LEN_W (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .words_done(words_done),
`ifdef COPY_MASTER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .avm       (avm)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:511];
    logic          wreq = 1'b0;
    logic          rand_en = 1'b0;
    logic          rdv = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [DW-1:0] pl_d = '0;

    assign avm.avm_waitrequest   = wreq;
    assign avm.avm_readdatavalid = rdv;
    assign avm.avm_readdata      = rdata;

    always @(posedge clk) begin
        rdv <= 1'b0;
        if (avm.avm_read && !wreq) begin
            rdata <= mem[avm.avm_address];
            rdv   <= 1'b1;
        end
        if (avm.avm_write && !wreq && avm.avm_byteenable == 4'hF)
            mem[avm.avm_address] <= avm.avm_writedata;
        if (pl_en)
            mem[pl_a] <= pl_d;
    end

    always @(negedge clk)
        wreq <= rand_en ? 1'($urandom_range(0, 1)) : 1'b0;

    int            reqs = 0;
    int            viol = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] p_a = '0;
    logic [DW-1:0] p_w = '0;
    logic          p_r = 1'b0;
    logic          p_wr = 1'b0;

    // A stalled request must reappear unchanged on the next edge
    always @(posedge clk) begin
        if (avm.avm_read || avm.avm_write)
            reqs <= reqs + 1;
        if (pend && (p_a != avm.avm_address || p_w != avm.avm_writedata ||
                     p_r != avm.avm_read || p_wr != avm.avm_write))
            viol <= viol + 1;
        pend <= (avm.avm_read || avm.avm_write) && wreq;
        p_a  <= avm.avm_address;
        p_w  <= avm.avm_writedata;
        p_r  <= avm.avm_read;
        p_wr <= avm.avm_write;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pl(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] l);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = l;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000)
            chk("done_timeout", {31'b0, done}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r0;
        int v0;
        int n;
        int dn;

        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_abt", {31'b0, aborted}, 0);
        chk("rst_wd", {22'b0, words_done}, 0);
        chk("rst_rd", {31'b0, avm.avm_read}, 0);
        chk("rst_wr", {31'b0, avm.avm_write}, 0);
        chk("rst_cs", {31'b0, avm.avm_chipselect}, 0);
        chk("rst_be", {28'b0, avm.avm_byteenable}, 0);
        chk("rst_addr", {23'b0, avm.avm_address}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) pl(AW'(i), DW'(i + 1));
        do_start(9'd0, 9'd100, 10'd4);
        chk("busy_run", {31'b0, busy}, 1);
        wait_done(c);
        chk("cyc4", c, 12);
        chk("wd4", {22'b0, words_done}, 4);
        chk("abt4", {31'b0, aborted}, 0);
        chk("busy_fin", {31'b0, busy}, 0);
        @(negedge clk);
        chk("done_1cyc", {31'b0, done}, 0);
        chk("wd4_hold", {22'b0, words_done}, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cp4_%0d", i), mem[100 + i], 32'(i + 1));

        r0 = reqs;
        do_start(9'd5, 9'd6, 10'd0);
        wait_done(c);
        chk("cyc0", c, 0);
        chk("wd0", {22'b0, words_done}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("req0", reqs - r0, 0);

        pl(9'd510, 32'h0000_A510);
        pl(9'd511, 32'h0000_A511);
        do_start(9'd510, 9'd20, 10'd4);
        wait_done(c);
        chk("wrap0", mem[20], 32'h0000_A510);
        chk("wrap1", mem[21], 32'h0000_A511);
        chk("wrap2", mem[22], 32'h1);
        chk("wrap3", mem[23], 32'h2);

        for (int i = 0; i < 16; i++)
            pl(AW'(40 + i), 32'h5A00_0000 + 32'(i * 7));
        v0 = viol;
        rand_en = 1'b1;
        do_start(9'd40, 9'd60, 10'd16);
        repeat (6) @(negedge clk);
        src_addr = 9'd40;
        dst_addr = 9'd0;
        length   = 10'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c);
        rand_en = 1'b0;
        chk("wd16", {22'b0, words_done}, 16);
        @(negedge clk);
        @(negedge clk);
        chk("stall_stable", viol - v0, 0);
        chk("busy_start_ign", mem[0], 32'h1);
        chk("idle_after16", {31'b0, busy}, 0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("cp16_%0d", i), mem[60 + i],
                32'h5A00_0000 + 32'(i * 7));

        for (int i = 0; i < 5; i++) begin
            pl(AW'(200 + i), 32'hC000_0000 + 32'(i));
            pl(AW'(300 + i), 32'hDEAD_0000 + 32'(i));
        end
        do_start(9'd200, 9'd300, 10'd5);
        n = 0;
        while (!(avm.avm_read && words_done == 10'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ab_find", {31'b0, avm.avm_read}, 1);
        @(negedge clk);
        chk("ab_rwait", {30'b0, avm.avm_read, avm.avm_write}, 0);
        abort = 1'b1;
        wait_done(c);
        abort = 1'b0;
        chk("ab_wd", {22'b0, words_done}, 2);
        chk("ab_flag", {31'b0, aborted}, 1);
        chk("ab_m0", mem[300], 32'hC000_0000);
        chk("ab_m1", mem[301], 32'hC000_0001);
        chk("ab_m2", mem[302], 32'hDEAD_0002);
        @(negedge clk);
        chk("ab_hold", {31'b0, aborted}, 1);

        do_start(9'd0, 9'd400, 10'd1);
        wait_done(c);
        chk("cyc1", c, 3);
        chk("ab_clr", {31'b0, aborted}, 0);
        chk("cp1", mem[400], 32'h1);

`ifdef COPY_MASTER_CHECKSUM_EN
        pl(9'd128, 32'hFFFF_FFFF);
        pl(9'd129, 32'h0000_0002);
        do_start(9'd128, 9'd144, 10'd2);
        wait_done(c);
        chk("csum", checksum, 32'h0000_0001);
`endif

        do_start(9'd0, 9'd450, 10'd4);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_busy", {31'b0, busy}, 0);
        chk("ar_req", {29'b0, avm.avm_read, avm.avm_write,
                       avm.avm_chipselect}, 0);
        chk("ar_wd", {22'b0, words_done}, 0);
        chk("ar_addr", {23'b0, avm.avm_address}, 0);
        chk("ar_wdata", avm.avm_writedata, 0);
`ifdef COPY_MASTER_CHECKSUM_EN
        chk("ar_csum", checksum, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("ar_nodone", dn, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
